reg_memwb_pipe: RTL
===================

REG_MEMWB_PIPE -- requirements
Module: reg_memwb_pipe

Interface
REQ-001 SHALL have parameter DW, default 32: width of the D and C data words.
REQ-002 SHALL have parameter RW, default 5: width of the destination register index.
REQ-003 SHALL have port Clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port Clr, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have ports Wreg and Reg2reg, input, 1 each: MEM-stage register-write enable and result select.
REQ-006 SHALL have ports D and C, input, DW each: MEM-stage memory data and ALU result.
REQ-007 SHALL have port Rd, input, RW: MEM-stage destination register index.
REQ-008 SHALL have port in_valid, input, 1: the MEM-stage payload is valid this cycle.
REQ-009 SHALL have port in_ready, output, 1: the stage can accept a payload this cycle.
REQ-010 SHALL have port out_ready, input, 1: the WB stage consumes the output this cycle.
REQ-011 SHALL have port Flush, input, 1: synchronous discard of all held and incoming payloads.
REQ-012 SHALL have ports wWreg, wReg2reg (1), wD, wC (DW) and wRd (RW), output: the WB-stage payload.
REQ-013 SHALL have port out_valid, output, 1: the WB-stage payload is valid.
REQ-014 SHALL have port occ, output, 2: number of held payloads (0..2).

Function
REQ-015 SHALL hold two payload slots: a main slot that drives the outputs and a skid slot for overflow, each with its own valid bit.
REQ-016 SHALL define accept as in_valid & in_ready, and in_ready as NOT skid_valid, taken from a register only (no combinational path from out_ready).
REQ-017 SHALL define drain as main_valid & out_ready.
REQ-018 SHALL load main from skid when main is empty or drains and skid_valid=1, then clear skid_valid.
REQ-019 SHALL otherwise load main from the inputs when main is empty or drains and accept=1.
REQ-020 SHALL clear main_valid when main drains and no new payload is loaded.
REQ-021 SHALL load skid from the inputs and set skid_valid when accept=1 while main_valid=1 and out_ready=0.
REQ-022 SHALL have a latency of 1 cycle from accept to out_valid when the stage is empty, and SHALL sustain 1 payload per cycle while out_ready=1.
REQ-023 SHALL keep payload order first-in first-out, with no loss or duplication.
REQ-024 SHALL hold the main payload stable while out_valid=1 and out_ready=0.
REQ-025 SHALL drive wWreg as main_valid & main.Wreg, so an invalid slot never requests a register write.
REQ-026 SHALL give Flush priority over every load: on the next edge both valid bits are 0 and a same-cycle accepted input is dropped; slot data may be retained.
REQ-027 SHALL drive occ as main_valid + skid_valid.
REQ-028 SHALL treat in_valid=0 as no event; other inputs are don't-care in that case.

Reset
REQ-029 SHALL, while Clr=1, asynchronously force both valid bits and all slot data to 0.
REQ-030 SHALL, during reset, drive out_valid=0, wWreg=0, wReg2reg=0, wD=0, wC=0, wRd=0, occ=0 and in_ready=1.
REQ-031 SHALL discard any in-flight payload when reset is asserted mid-operation.
REQ-032 SHALL resume normal operation on the first rising Clk edge after Clr deasserts.

Structure
REQ-033 SHALL take the default DW and RW and the derived payload width PW=2+2*DW+RW from the shared package memwb_pkg.
REQ-034 SHALL build each slot from one sub-module, memwb_slot: a PW-bit register with load enable and asynchronous active-high clear, instantiated twice.

Verification
REQ-035 SHALL test reset: Clr=1 mid-stream with occ=2 -> immediately out_valid=0, wWreg=0, occ=0, in_ready=1.
REQ-036 SHALL test streaming: out_ready=1, in_valid=1 for 8 cycles with D=C=i, Rd=i -> wD=i one cycle later, occ never above 1.
REQ-037 SHALL test a stall: with out_ready=0, send payloads A (D=0x11) and B (D=0x22) -> occ=2, in_ready=0, wD=0x11 held; raising out_ready gives 0x11 then 0x22.
REQ-038 SHALL test flush: Flush=1 with occ=2 and in_valid=1 -> next cycle occ=0, out_valid=0, wWreg=0, and the incoming payload never appears.
REQ-039 SHALL test simultaneous events: occ=1 with out_ready=1 and accept in the same cycle -> occ stays 1 and wD takes the new value.
REQ-040 SHALL test write gating: a payload with Wreg=1 is flushed -> wWreg stays 0 on every cycle.

Source files
------------

// File: rtl/memwb_pkg.sv
// rtl/memwb_pkg.sv - shared widths for the MEM/WB pipeline register
package memwb_pkg;
   localparam int DW_DEF = 32;
   localparam int RW_DEF = 5;

   // Payload layout, MSB first: Wreg, Reg2reg, D, C, Rd.
   function automatic int payload_width(int dw, int rw);
      return 2 + 2 * dw + rw;
   endfunction

   localparam int PW_DEF = payload_width(DW_DEF, RW_DEF);
endpackage

// File: rtl/memwb_slot.sv
// rtl/memwb_slot.sv - payload register with load enable and async clear
module memwb_slot #(
   parameter int W = memwb_pkg::PW_DEF
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         load,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   always_ff @(posedge clk or posedge clr) begin
      if (clr)
         q <= '0;
      else if (load)
         q <= d;
   end
endmodule

// File: rtl/reg_memwb_pipe.sv
// rtl/reg_memwb_pipe.sv - MEM/WB pipeline register with skid buffer and flush
module reg_memwb_pipe
   import memwb_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int RW = RW_DEF
) (
   input  logic          Clk,
   input  logic          Clr,
   input  logic          Wreg,
   input  logic          Reg2reg,
   input  logic [DW-1:0] D,
   input  logic [DW-1:0] C,
   input  logic [RW-1:0] Rd,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic          out_ready,
   input  logic          Flush,
   output logic          wWreg,
   output logic          wReg2reg,
   output logic [DW-1:0] wD,
   output logic [DW-1:0] wC,
   output logic [RW-1:0] wRd,
   output logic          out_valid,
   output logic [1:0]    occ
);
   localparam int PW = payload_width(DW, RW);

   logic          main_valid;
   logic          skid_valid;
   logic [PW-1:0] in_pl;
   logic [PW-1:0] main_d;
   logic [PW-1:0] main_q;
   logic [PW-1:0] skid_q;
   logic          accept;
   logic          drain;
   logic          main_free;
   logic          main_from_skid;
   logic          main_from_in;
   logic          skid_fill;
   logic          main_load;
   logic          skid_load;

   assign in_pl = {Wreg, Reg2reg, D, C, Rd};

   // in_ready depends only on the skid register, so no out_ready->in_ready path.
   assign in_ready       = ~skid_valid;
   assign accept         = in_valid & in_ready;
   assign drain          = main_valid & out_ready;
   assign main_free      = ~main_valid | out_ready;
   assign main_from_skid = main_free & skid_valid;
   assign main_from_in   = main_free & ~skid_valid & accept;
   assign skid_fill      = accept & main_valid & ~out_ready;

   assign main_load = ~Flush & (main_from_skid | main_from_in);
   assign skid_load = ~Flush & skid_fill;
   assign main_d    = skid_valid ? skid_q : in_pl;

   memwb_slot #(.W(PW)) u_main (
      .clk  (Clk),
      .clr  (Clr),
      .load (main_load),
      .d    (main_d),
      .q    (main_q)
   );

   memwb_slot #(.W(PW)) u_skid (
      .clk  (Clk),
      .clr  (Clr),
      .load (skid_load),
      .d    (in_pl),
      .q    (skid_q)
   );

   always_ff @(posedge Clk or posedge Clr) begin
      if (Clr) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
      end else if (Flush) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
      end else begin
         if (main_from_skid || main_from_in)
            main_valid <= 1'b1;
         else if (drain)
            main_valid <= 1'b0;

         if (skid_fill)
            skid_valid <= 1'b1;
         else if (main_from_skid)
            skid_valid <= 1'b0;
      end
   end

   // Register-write request is gated so a stale slot never writes the register file.
   assign wWreg     = main_valid & main_q[PW-1];
   assign wReg2reg  = main_q[PW-2];
   assign wD        = main_q[PW-3 -: DW];
   assign wC        = main_q[RW +: DW];
   assign wRd       = main_q[RW-1:0];
   assign out_valid = main_valid;
   assign occ       = {1'b0, main_valid} + {1'b0, skid_valid};
endmodule
